// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller for the 5-stage TSC core: data/control stalls,
// branch-stall FSM, memory-busy freeze, halt state and saturating perf counters.
//
// state   | meaning
// RUN     | normal issue; data/control hazard and halt detection active
// BR_WAIT | stall-until-resolved branch in flight; br_cnt_q cycles remain
// HALTED  | HLT retired; pipeline held until reset
module hazard_ctrl #(
  parameter int RA_W               = 2,
  parameter int DATA_FORWARDING    = 1,
  parameter int RF_SELF_FORWARDING = 1,
  parameter int BRANCH_MODE        = 1,
  parameter int BR_STALL_CYCLES    = 2,
  parameter int CNT_W              = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             use_rs,
  input  logic             use_rt,
  input  logic             use_rs_at_id,
  input  logic             is_branch_id,
  input  logic             is_jump_id,
  input  logic             is_halt_id,
  input  logic [RA_W-1:0]  rs_id,
  input  logic [RA_W-1:0]  rt_id,
  input  logic             reg_write_ex,
  input  logic             reg_write_mem,
  input  logic             reg_write_wb,
  input  logic [RA_W-1:0]  write_reg_ex,
  input  logic [RA_W-1:0]  write_reg_mem,
  input  logic [RA_W-1:0]  write_reg_wb,
  input  logic             d_mem_read_ex,
  input  logic             d_mem_read_mem,
  input  logic             d_mem_read_wb,
  input  logic [RA_W-1:0]  rt_ex,
  input  logic [RA_W-1:0]  rt_mem,
  input  logic [RA_W-1:0]  rt_wb,
  input  logic             branch_ex,
  input  logic             branch_miss,
  input  logic             mem_busy,
  input  logic             cnt_clear,
  output logic             bubblify,
  output logic             flush_if,
  output logic             pc_write,
  output logic             ir_write,
  output logic             freeze,
  output logic             incr_num_inst,
  output logic             halted,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] inst_count
);

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    BR_WAIT = 2'd1,
    HALTED  = 2'd2
  } state_e;

  localparam logic       NO_FWD  = (DATA_FORWARDING == 0);
  localparam logic       NO_RFSF = (RF_SELF_FORWARDING == 0);
  localparam logic       BR_PRED = (BRANCH_MODE != 0);
  localparam logic       BR_MULTI = (BR_STALL_CYCLES > 1);
  localparam logic [3:0] BR_INIT = 4'(BR_STALL_CYCLES - 1);

  state_e           state_q, state_d;
  logic [3:0]       br_cnt_q, br_cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] inst_cnt_q, inst_cnt_d;

  logic ex_rs, mem_rs, wb_rs, ld_rs;
  logic ex_rt, mem_rt, wb_rt, ld_rt;
  logic rs_hit, rt_hit, data_stall;
  logic stall_evt;

  // MEM/WB load tags are informational only; load-use is resolved against EX.
  logic unused_ld_tags;
  assign unused_ld_tags = ^{d_mem_read_mem, d_mem_read_wb, rt_mem, rt_wb};

  assign ex_rs  = reg_write_ex  & (write_reg_ex  == rs_id);
  assign mem_rs = reg_write_mem & (write_reg_mem == rs_id);
  assign wb_rs  = reg_write_wb  & (write_reg_wb  == rs_id);
  assign ld_rs  = d_mem_read_ex & (rt_ex == rs_id);
  assign ex_rt  = reg_write_ex  & (write_reg_ex  == rt_id);
  assign mem_rt = reg_write_mem & (write_reg_mem == rt_id);
  assign wb_rt  = reg_write_wb  & (write_reg_wb  == rt_id);
  assign ld_rt  = d_mem_read_ex & (rt_ex == rt_id);

  // A register consumed in ID cannot use the EX/MEM bypass, so EX always stalls it.
  assign rs_hit = (use_rs | use_rs_at_id) &
                  ((NO_FWD & (ex_rs | mem_rs)) | (NO_RFSF & wb_rs) |
                   (use_rs_at_id & ex_rs) | ld_rs);
  assign rt_hit = use_rt &
                  ((NO_FWD & (ex_rt | mem_rt)) | (NO_RFSF & wb_rt) | ld_rt);
  assign data_stall = rs_hit | rt_hit;

  always_comb begin
    state_d   = state_q;
    br_cnt_d  = br_cnt_q;
    bubblify  = 1'b0;
    flush_if  = 1'b0;
    pc_write  = 1'b1;
    ir_write  = 1'b1;
    freeze    = 1'b0;

    if (mem_busy) begin
      freeze   = 1'b1;
      pc_write = 1'b0;
      ir_write = 1'b0;
    end else begin
      case (state_q)
        HALTED: begin
          pc_write = 1'b0;
          ir_write = 1'b0;
          bubblify = 1'b1;
        end
        BR_WAIT: begin
          flush_if = 1'b1;
          pc_write = (br_cnt_q == 4'd1);
          br_cnt_d = br_cnt_q - 4'd1;
          if (br_cnt_q == 4'd1) state_d = RUN;
        end
        default: begin
          if (data_stall) begin
            pc_write = 1'b0;
            ir_write = 1'b0;
            bubblify = 1'b1;
          end else if (BR_PRED && (is_jump_id || (branch_ex && branch_miss))) begin
            flush_if = 1'b1;
            bubblify = branch_ex & branch_miss;
          end else if (!BR_PRED && (is_branch_id || is_jump_id)) begin
            flush_if = 1'b1;
            pc_write = 1'b0;
            if (BR_MULTI) begin
              br_cnt_d = BR_INIT;
              state_d  = BR_WAIT;
            end
          end else if (is_halt_id) begin
            pc_write = 1'b0;
            ir_write = 1'b0;
            bubblify = 1'b1;
            state_d  = HALTED;
          end
        end
      endcase
    end
  end

  assign incr_num_inst = ~(bubblify | flush_if | freeze);
  assign halted        = (state_q == HALTED);
  assign stall_evt     = (bubblify | flush_if | freeze) & ~halted;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    inst_cnt_d  = inst_cnt_q;
    if (cnt_clear) begin
      stall_cnt_d = '0;
      inst_cnt_d  = '0;
    end else begin
      if (stall_evt && !(&stall_cnt_q)) stall_cnt_d = stall_cnt_q + 1'b1;
      if (incr_num_inst && !(&inst_cnt_q)) inst_cnt_d = inst_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= RUN;
      br_cnt_q    <= 4'd0;
      stall_cnt_q <= '0;
      inst_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      br_cnt_q    <= br_cnt_d;
      stall_cnt_q <= stall_cnt_d;
      inst_cnt_q  <= inst_cnt_d;
    end
  end

  assign stall_count = stall_cnt_q;
  assign inst_count  = inst_cnt_q;

endmodule
